sc_fifo_ctrl: RTL and testbench

- Pointer/flag controller that turns the slave-FIFO dual-port memory (active-low write/read enables, registered read address, W=8, L=5) into a synchronous single-clock FIFO.
- Accepts push/pop requests from the channel side and drives the memory write port and read-address port.
- Returns popped data with a valid strobe and reports full, empty, almost-full and fill level to the MCDF arbiter.

---
 rtl/sc_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_sc_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sc_fifo_ctrl                                                 |
// | Description : Pointer/flag controller that wraps a dual-port memory with   |
// |               active-low write/read enables and a registered read address |
// |               into a synchronous single-clock FIFO of depth 2^L.          |
// |               Optional sticky overflow/underflow flags are enabled by      |
// |               defining SC_FIFO_ERR_FLAG_EN.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sc_fifo_ctrl #(
  parameter int W        = 8,
  parameter int L        = 5,
  parameter int AF_LEVEL = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         pop_vld_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         almost_full_o,
  output logic [L:0]   level_o,
`ifdef SC_FIFO_ERR_FLAG_EN
  output logic         ovf_o,
  output logic         udf_o,
`endif
  output logic         mem_wr_n_o,
  output logic [L-1:0] mem_waddr_o,
  output logic [W-1:0] mem_wdata_o,
  output logic         mem_rd_n_o,
  output logic [L-1:0] mem_raddr_o,
  input  logic [W-1:0] mem_rdata_i
);

  localparam logic [L:0] AF_LVL = (L+1)'(AF_LEVEL);
  localparam logic [L:0] ONE    = (L+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [L:0] wr_ptr_q, wr_ptr_d;
  logic [L:0] rd_ptr_q, rd_ptr_d;
  logic [L:0] level_q,  level_d;
  logic       pop_vld_q, pop_vld_d;
  logic       full_w, empty_w;
  logic       push_ok, pop_ok;

  // Flags, accept decisions and next-state values, all from registered state.
  always_comb begin
    full_w    = (wr_ptr_q[L] != rd_ptr_q[L]) && (wr_ptr_q[L-1:0] == rd_ptr_q[L-1:0]);
    empty_w   = (wr_ptr_q == rd_ptr_q);
    push_ok   = push_i & ~full_w;
    pop_ok    = pop_i & ~empty_w;
    wr_ptr_d  = push_ok ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d  = pop_ok  ? rd_ptr_q + ONE : rd_ptr_q;
    pop_vld_d = pop_ok;
    level_d   = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
  end

  // Core state register; reset discards all stored words logically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pop_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pop_vld_q <= pop_vld_d;
    end
  end

  // Memory port drive and status outputs; read data passes straight through.
  always_comb begin
    mem_wr_n_o    = ~push_ok;
    mem_waddr_o   = wr_ptr_q[L-1:0];
    mem_wdata_o   = push_data_i;
    mem_rd_n_o    = ~pop_ok;
    mem_raddr_o   = rd_ptr_q[L-1:0];
    pop_data_o    = mem_rdata_i;
    pop_vld_o     = pop_vld_q;
    full_o        = full_w;
    empty_o       = empty_w;
    level_o       = level_q;
    almost_full_o = (level_q >= AF_LVL);
  end

`ifdef SC_FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags record any rejected request until the next reset.
  always_comb begin
    ovf_d = ovf_q | (push_i & full_w);
    udf_d = udf_q | (pop_i & empty_w);
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sc_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sc_fifo_ctrl                                              |
// | Description : Self-checking bench for sc_fifo_ctrl with a memory model    |
// |               and a queue-based FIFO reference.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sc_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop;
  logic [7:0] push_data;
  logic [7:0] pop_data;
  logic       pop_vld, full, empty, almost_full;
  logic [5:0] level;
  logic       mem_wr_n, mem_rd_n;
  logic [4:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata;
`ifdef SC_FIFO_ERR_FLAG_EN
  logic       ovf, udf;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] q[$];
  int         wr_cnt, rd_cnt;
  logic       exp_ovf, exp_udf;

  sc_fifo_ctrl #(.W(8), .L(5), .AF_LEVEL(28)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .pop_data_o   (pop_data),
    .pop_vld_o    (pop_vld),
    .full_o       (full),
    .empty_o      (empty),
    .almost_full_o(almost_full),
    .level_o      (level),
`ifdef SC_FIFO_ERR_FLAG_EN
    .ovf_o        (ovf),
    .udf_o        (udf),
`endif
    .mem_wr_n_o   (mem_wr_n),
    .mem_waddr_o  (mem_waddr),
    .mem_wdata_o  (mem_wdata),
    .mem_rd_n_o   (mem_rd_n),
    .mem_raddr_o  (mem_raddr),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Dual-port memory: active-low write, registered read address.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (!mem_wr_n) mem[mem_waddr] <= mem_wdata;
    if (!mem_rd_n) mem_rdata <= mem[mem_raddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    wr_cnt  = 0;
    rd_cnt  = 0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  // One clock of stimulus with the model advanced and all outputs compared.
  task automatic step(input logic p, input logic [7:0] d, input logic r);
    logic       push_ok, pop_ok;
    logic [7:0] exp_d;
    logic [5:0] exp_lvl;
    int         sz;
    @(negedge clk);
    push = p; push_data = d; pop = r;
    sz      = q.size();
    push_ok = p && (sz < 32);
    pop_ok  = r && (sz > 0);
    exp_d   = 8'h00;
    #1;
    checks++;
    if (mem_wr_n !== !push_ok || mem_rd_n !== !pop_ok) begin
      failures++;
      $display("FAIL enables: wr_n=%b rd_n=%b required wr_n=%b rd_n=%b", mem_wr_n, mem_rd_n, !push_ok, !pop_ok);
    end
    checks++;
    if (mem_waddr !== 5'(wr_cnt) || mem_raddr !== 5'(rd_cnt)) begin
      failures++;
      $display("FAIL addr: waddr=%0d raddr=%0d required waddr=%0d raddr=%0d", mem_waddr, mem_raddr, wr_cnt % 32, rd_cnt % 32);
    end
    if (push_ok) begin
      checks++;
      if (mem_wdata !== d) begin
        failures++;
        $display("FAIL wdata: got %h required %h", mem_wdata, d);
      end
    end
    if (p && sz == 32) exp_ovf = 1'b1;
    if (r && sz == 0)  exp_udf = 1'b1;
    @(posedge clk);
    #1;
    if (pop_ok)  begin exp_d = q.pop_front(); rd_cnt++; end
    if (push_ok) begin q.push_back(d); wr_cnt++; end
    exp_lvl = 6'(q.size());
    checks++;
    if (pop_vld !== pop_ok) begin
      failures++;
      $display("FAIL pop_vld: got %b required %b", pop_vld, pop_ok);
    end
    if (pop_ok) begin
      checks++;
      if (pop_data !== exp_d) begin
        failures++;
        $display("FAIL pop_data: got %h required %h", pop_data, exp_d);
      end
    end
    checks++;
    if (level !== exp_lvl || full !== (exp_lvl == 6'd32) || empty !== (exp_lvl == 6'd0)
        || almost_full !== (exp_lvl >= 6'd28)) begin
      failures++;
      $display("FAIL status: level=%0d full=%b empty=%b af=%b required level=%0d full=%b empty=%b af=%b",
               level, full, empty, almost_full, exp_lvl, exp_lvl == 6'd32, exp_lvl == 6'd0, exp_lvl >= 6'd28);
    end
`ifdef SC_FIFO_ERR_FLAG_EN
    checks++;
    if (ovf !== exp_ovf || udf !== exp_udf) begin
      failures++;
      $display("FAIL errflags: ovf=%b udf=%b required ovf=%b udf=%b", ovf, udf, exp_ovf, exp_udf);
    end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (pop_vld !== 1'b0 || level !== 6'd0 || empty !== 1'b1 || full !== 1'b0
        || almost_full !== 1'b0 || mem_wr_n !== 1'b1 || mem_rd_n !== 1'b1) begin
      failures++;
      $display("FAIL %s: vld=%b level=%0d empty=%b full=%b af=%b wr_n=%b rd_n=%b required 0 0 1 0 0 1 1",
               tag, pop_vld, level, empty, full, almost_full, mem_wr_n, mem_rd_n);
    end
`ifdef SC_FIFO_ERR_FLAG_EN
    checks++;
    if (ovf !== 1'b0 || udf !== 1'b0) begin
      failures++;
      $display("FAIL %s_err: ovf=%b udf=%b required 0 0", tag, ovf, udf);
    end
`endif
  endtask

  task automatic test_reset();
    push = 1'b0; pop = 1'b0; push_data = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b0);
    checks++;
    if (full !== 1'b1 || level !== 6'd32) begin
      failures++;
      $display("FAIL fill_full: full=%b level=%0d required full=1 level=32", full, level);
    end
    step(1'b1, 8'hAA, 1'b0);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty: empty=%b required 1", empty);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      checks++;
      if (level !== 6'd3) begin
        failures++;
        $display("FAIL wrap_level: level=%0d required 3", level);
      end
    end
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_simultaneous();
    step(1'b1, 8'h11, 1'b1);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    while (q.size() < 32) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    checks++;
    if (level !== 6'd31) begin
      failures++;
      $display("FAIL simul_full: level=%0d required 31", level);
    end
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 99) < 40), 8'($urandom), 1'($urandom_range(0, 99) < 60));
  endtask

  task automatic test_mid_reset();
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (pop_vld !== 1'b1 || level !== 6'd10) begin
      failures++;
      $display("FAIL midrst_setup: vld=%b level=%0d required vld=1 level=10", pop_vld, level);
    end
    push = 1'b0; pop = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (pop_vld !== 1'b1 || pop_data !== 8'h55) begin
      failures++;
      $display("FAIL midrst_data: vld=%b data=%h required vld=1 data=55", pop_vld, pop_data);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
